// File: rtl/ht09_encoder.sv
// MPEG-1 Layer III big-value Huffman table 9 encoder (linbits = 0).
// Takes one signed (x,y) pair per handshake and streams codeword, x sign, y sign MSB-first,
// one bit per cycle. Define HT09_CLIP_EN to saturate out-of-range magnitudes instead of dropping.
module ht09_encoder #(
  parameter int unsigned MAX_BITS = 9,
  parameter int unsigned MAX_ABS  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  output logic        in_ready,
  input  logic [15:0] x_val,
  input  logic [15:0] y_val,
  output logic        axiov,
  output logic        axiod,
  output logic        axiol,
  input  logic        out_ready,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, CODE, XSIGN, YSIGN} state_e;

  state_e              r_state, w_state_nxt;
  logic [MAX_BITS-1:0] r_code, w_code_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_xs, w_xs_nxt, r_ys, w_ys_nxt;
  logic                r_xnz, w_xnz_nxt, r_ynz, w_ynz_nxt;
  logic                r_err, w_err_nxt;

  // {length[3:0], codeword right-aligned[8:0]} indexed by (|x|,|y|)
  function automatic logic [12:0] lut(input logic [2:0] x, input logic [2:0] y);
    case ({x, y})
      6'o00: lut = {4'd3, 9'd7};   6'o01: lut = {4'd3, 9'd5};   6'o02: lut = {4'd5, 9'd9};
      6'o03: lut = {4'd6, 9'd14};  6'o04: lut = {4'd8, 9'd15};  6'o05: lut = {4'd9, 9'd7};
      6'o10: lut = {4'd3, 9'd6};   6'o11: lut = {4'd3, 9'd4};   6'o12: lut = {4'd4, 9'd5};
      6'o13: lut = {4'd5, 9'd5};   6'o14: lut = {4'd6, 9'd6};   6'o15: lut = {4'd8, 9'd7};
      6'o20: lut = {4'd4, 9'd7};   6'o21: lut = {4'd4, 9'd6};   6'o22: lut = {4'd5, 9'd8};
      6'o23: lut = {4'd6, 9'd8};   6'o24: lut = {4'd7, 9'd8};   6'o25: lut = {4'd8, 9'd5};
      6'o30: lut = {4'd6, 9'd15};  6'o31: lut = {4'd5, 9'd6};   6'o32: lut = {4'd6, 9'd9};
      6'o33: lut = {4'd7, 9'd10};  6'o34: lut = {4'd7, 9'd5};   6'o35: lut = {4'd8, 9'd1};
      6'o40: lut = {4'd7, 9'd11};  6'o41: lut = {4'd6, 9'd7};   6'o42: lut = {4'd7, 9'd9};
      6'o43: lut = {4'd7, 9'd6};   6'o44: lut = {4'd8, 9'd4};   6'o45: lut = {4'd9, 9'd1};
      6'o50: lut = {4'd8, 9'd14};  6'o51: lut = {4'd7, 9'd4};   6'o52: lut = {4'd8, 9'd6};
      6'o53: lut = {4'd8, 9'd2};   6'o54: lut = {4'd9, 9'd6};   6'o55: lut = {4'd9, 9'd0};
      default: lut = '0;
    endcase
  endfunction

  // 17-bit magnitude so that -32768 yields +32768 and lands out of range
  logic [16:0]         w_xabs, w_yabs;
  logic                w_xoor, w_yoor, w_drop;
  logic [2:0]          w_xmag, w_ymag;
  logic [12:0]         w_lut;
  logic [3:0]          w_len;
  logic [MAX_BITS-1:0] w_cw_al;
  logic                w_out_xfer, w_in_xfer, w_load;

  assign w_xabs = x_val[15] ? (17'd0 - {1'b1, x_val}) : {1'b0, x_val};
  assign w_yabs = y_val[15] ? (17'd0 - {1'b1, y_val}) : {1'b0, y_val};
  assign w_xoor = w_xabs > 17'(MAX_ABS);
  assign w_yoor = w_yabs > 17'(MAX_ABS);

`ifdef HT09_CLIP_EN
  assign w_xmag = w_xoor ? 3'(MAX_ABS) : w_xabs[2:0];
  assign w_ymag = w_yoor ? 3'(MAX_ABS) : w_yabs[2:0];
  assign w_drop = 1'b0;
`else
  assign w_xmag = w_xabs[2:0];
  assign w_ymag = w_yabs[2:0];
  assign w_drop = w_xoor | w_yoor;
`endif

  assign w_lut   = lut(w_xmag, w_ymag);
  assign w_len   = w_lut[12:9];
  // Left-align so the next bit to send is always the register MSB
  assign w_cw_al = MAX_BITS'(w_lut[8:0]) << (4'(MAX_BITS) - w_len);

  // Output decode and handshakes from the current state
  always_comb begin
    axiov = 1'b0;
    axiod = 1'b0;
    axiol = 1'b0;
    case (r_state)
      CODE: begin
        axiov = 1'b1;
        axiod = r_code[MAX_BITS-1];
        axiol = (r_cnt == CNT_W'(1)) && !r_xnz && !r_ynz;
      end
      XSIGN: begin
        axiov = 1'b1;
        axiod = r_xs;
        axiol = !r_ynz;
      end
      YSIGN: begin
        axiov = 1'b1;
        axiod = r_ys;
        axiol = 1'b1;
      end
      default: ;
    endcase
    w_out_xfer = axiov && out_ready;
    in_ready   = (r_state == IDLE) || (w_out_xfer && axiol);
    w_in_xfer  = axiiv && in_ready;
    w_load     = w_in_xfer && !w_drop;
    err        = r_err;
  end

  // Next-state: advance on output transfer, skipping zero-valued signs; load overrides
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_xs_nxt    = r_xs;
    w_ys_nxt    = r_ys;
    w_xnz_nxt   = r_xnz;
    w_ynz_nxt   = r_ynz;
    w_err_nxt   = w_in_xfer && (w_xoor || w_yoor);
    if (w_out_xfer) begin
      case (r_state)
        CODE: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = r_xnz ? XSIGN : (r_ynz ? YSIGN : IDLE);
          end
          w_code_nxt = r_code << 1;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
        end
        XSIGN:   w_state_nxt = r_ynz ? YSIGN : IDLE;
        YSIGN:   w_state_nxt = IDLE;
        default: ;
      endcase
    end
    if (w_load) begin
      w_state_nxt = CODE;
      w_code_nxt  = w_cw_al;
      w_cnt_nxt   = CNT_W'(w_len);
      w_xs_nxt    = x_val[15];
      w_ys_nxt    = y_val[15];
      w_xnz_nxt   = (w_xmag != 3'd0);
      w_ynz_nxt   = (w_ymag != 3'd0);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_cnt   <= '0;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_xnz   <= 1'b0;
      r_ynz   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xs    <= w_xs_nxt;
      r_ys    <= w_ys_nxt;
      r_xnz   <= w_xnz_nxt;
      r_ynz   <= w_ynz_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule
